// File: rtl/pixel_stream_to_axis.sv
// Converts a valid-only pixel stream (frame_start / line_end sideband) into AXI4-Stream video.
// Latency: a pixel written in cycle N is presented on m_axis_* in cycle N+1 (first-word fall-through).
// Backpressure: the source cannot be stalled. A full FIFO drops the pixel, sets overflow and resyncs on the next frame start.
// Optional build macro: PIXEL_STREAM_AXIS_STATS_EN enables frame_count / drop_count.
module pixel_stream_to_axis #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  frame_start_in,
  input  logic                  line_end_in,
  input  logic                  data_enable_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            full;
  logic            pop;
  logic            want;
  logic            push;
  logic            ovf_evt;
  logic [EW-1:0]   head;

  // FIFO status and the per-cycle write/pop/overflow decisions.
  // A full FIFO still accepts a pixel when the head is popped in the same cycle.
  always_comb begin
    full    = (count_q == DEPTH_C);
    pop     = m_axis_tvalid & m_axis_tready;
    want    = data_enable_in & ((state_q == ST_RUN) | frame_start_in);
    push    = want & (~full | pop);
    ovf_evt = want & full & ~pop;
  end

  // Next-state logic: SYNC/DROP wait for a frame start that fits; RUN leaves only on overflow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC, ST_DROP: begin
        if (push) begin
          state_d = ST_RUN;
        end else if (ovf_evt) begin
          state_d = ST_DROP;
        end
      end
      ST_RUN: begin
        if (ovf_evt) begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the output bus reads zero out of reset.
  // When full, wr_ptr equals rd_ptr: the head is read from the old contents before the write lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {frame_start_in, line_end_in, data_in};
    end
  end

  // Head entry drives the stream directly from registers, so it holds while stalled.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    m_axis_tvalid = (count_q != '0);
    m_axis_tdata  = head[DATA_WIDTH-1:0];
    m_axis_tlast  = head[DATA_WIDTH];
    m_axis_tuser  = head[DATA_WIDTH+1];
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_comb begin
    overflow_d = ovf_evt | (overflow_q & ~overflow_clear);
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef PIXEL_STREAM_AXIS_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_evt;

  // Saturating statistics: frames written and pixels discarded for any reason.
  always_comb begin
    drop_evt   = data_enable_in & ~push;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (push && frame_start_in && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign frame_count = 16'd0;
  assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_stream_to_axis.sv
// Randomized bench for pixel_stream_to_axis against a queue-based reference model.
// Latency: expected beats are checked one cycle after the pixel is driven.
// Backpressure: tready patterns (held, blocked, random) exercise stalls, overflow and resync.
module tb_pixel_stream_to_axis;

  localparam int DW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] data_in;
  logic          frame_start_in;
  logic          line_end_in;
  logic          data_enable_in;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          overflow;
  logic          overflow_clear;
  logic [15:0]   frame_count;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  pixel_stream_to_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .data_in        (data_in),
    .frame_start_in (frame_start_in),
    .line_end_in    (line_end_in),
    .data_enable_in (data_enable_in),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue holds exactly the beats still owed to downstream.
  logic [DW+1:0] exp_q[$];
  bit            accepting;
  bit            m_ovf;
  int            m_frames;
  int            m_drops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    accepting = 1'b0;
    m_ovf     = 1'b0;
    m_frames  = 0;
    m_drops   = 0;
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef PIXEL_STREAM_AXIS_STATS_EN
    return (v > 65535) ? 32'd65535 : 32'(v);
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Called at a falling edge: check outputs, drive one cycle of inputs, advance the model.
  task automatic cycle(input bit de, input bit fs, input bit le, input bit rdy, input bit clr);
    logic [DW-1:0] d;
    bit            want;
    bit            took;
    d = DW'($urandom);
    chk("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0][DW-1:0]));
      chk("tlast", 32'(m_axis_tlast), 32'(exp_q[0][DW]));
      chk("tuser", 32'(m_axis_tuser), 32'(exp_q[0][DW+1]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_count", 32'(frame_count), stat(m_frames));
    chk("drop_count", 32'(drop_count), stat(m_drops));

    data_in        = d;
    frame_start_in = fs;
    line_end_in    = le;
    data_enable_in = de;
    m_axis_tready  = rdy;
    overflow_clear = clr;

    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    want = de && (accepting || fs);
    took = want && (exp_q.size() < DEPTH);
    if (took) begin
      exp_q.push_back({fs, le, d});
      accepting = 1'b1;
      if (fs) m_frames++;
    end else begin
      if (de) m_drops++;
      if (want) accepting = 1'b0;
    end
    m_ovf = (want && !took) || (m_ovf && !clr);

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic frame(input int w, input int h, input bit rdy);
    for (int p = 0; p < w * h; p++) cycle(1'b1, p == 0, (p % w) == w - 1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    resetn = 1'b1;
  endtask

  initial begin
    resetn         = 1'b0;
    data_in        = '0;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
    data_enable_in = 1'b0;
    m_axis_tready  = 1'b0;
    overflow_clear = 1'b0;
    model_reset();
    #12;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 4x2 frame streamed straight through.
    frame(4, 2, 1'b1);
    idle(3, 1'b1);

    // Pixels before the first frame start are discarded.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(4, 1, 1'b1);
    idle(2, 1'b1);

    // Overflow with downstream blocked, drops until the next frame start.
    for (int p = 0; p < 17; p++) cycle(1'b1, p == 0, (p % 4) == 3, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(18, 1'b1);
    frame(4, 1, 1'b1);
    idle(2, 1'b1);

    // Push and pop together at full: accepted, occupancy stays at the limit.
    frame(4, 4, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(18, 1'b1);

    // Two frames under random backpressure and gaps.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        if ($urandom_range(0, 1) == 1) cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
        cycle(1'b1, p == 0, (p % 8) == 7, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end
    end
    idle(20, 1'b1);

    // Asynchronous reset in the middle of a line.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("arst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("arst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, i == 2, 1'b1, 1'b0);
    frame(4, 2, 1'b1);
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_to_axis.md
# pixel_stream_to_axis

Receiving end of the fractal pixel stream: accepts the 24-bit colorized pixel stream with its valid-only sideband (`data_enable`, `frame_start`, `line_end`) and re-emits it as AXI4-Stream video (`tuser` = start of frame, `tlast` = end of line) toward the VDMA/video output. The upstream source has no backpressure, so the block buffers pixels in a small FIFO. It detects overflow and resynchronises cleanly on the next frame start, so that downstream never sees a frame beginning mid-line.

## Interface

Parameters:
- `DATA_WIDTH`, 24: pixel width (`{R,B,G}` as produced upstream).
- `FIFO_DEPTH`, 16: buffer entries; power of two, minimum 4.

Ports:
- `clk`, in, 1: single clock for all logic.
- `resetn`, in, 1: asynchronous, active-low reset.
- `data_in`, in, `DATA_WIDTH`: pixel, valid when `data_enable_in`=1.
- `frame_start_in`, in, 1: first pixel of frame; qualified by `data_enable_in`.
- `line_end_in`, in, 1: last pixel of line; qualified by `data_enable_in`.
- `data_enable_in`, in, 1: pixel valid this cycle.
- `m_axis_tdata`, out, `DATA_WIDTH`: output pixel.
- `m_axis_tvalid`, out, 1: output beat valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tuser`, out, 1: start of frame.
- `m_axis_tlast`, out, 1: end of line.
- `overflow`, out, 1: sticky; set when a pixel was lost.
- `overflow_clear`, in, 1: single-cycle pulse that clears `overflow`.
- `frame_count`, out, 16: frames accepted (see Configuration).
- `drop_count`, out, 16: pixels discarded (see Configuration).

## Operation

- FIFO entry = `{frame_start_in, line_end_in, data_in}`, i.e. `DATA_WIDTH`+2 bits.
- A write is attempted on any cycle with `data_enable_in`=1. Whether it is taken depends on the state.
- State `SYNC` (reset state): discard pixels until `data_enable_in & frame_start_in`. That pixel is written and the state moves to `RUN`.
- State `RUN`: every pixel is written.
- A pixel with `frame_start_in`=1 in `RUN` (early or short frame) is written normally, with `tuser`=1. No state change.
- Overflow: a write is attempted when `count == FIFO_DEPTH` and no pop occurs in the same cycle.
  - The pixel is discarded.
  - `overflow` is set.
  - The state goes to `DROP`.
- State `DROP`: discard pixels until `data_enable_in & frame_start_in`.
  - That pixel is written if space exists, and the state goes to `RUN`.
  - If the FIFO is still full, the pixel is discarded and the state stays `DROP`.
  - Entries already queued always drain normally.
- Pop: when `m_axis_tvalid & m_axis_tready`.
- Simultaneous push and pop at full: the push is accepted; `count` is unchanged.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. `count` is `log2(FIFO_DEPTH)`+1 bits.
- `overflow_clear` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- Reset values:
  - State `SYNC`; FIFO empty.
  - `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast` = 0; `m_axis_tdata` = 0.
  - `overflow` = 0; `frame_count` = 0; `drop_count` = 0.
- Reset asserted mid-frame: all contents are lost, and the block restarts in `SYNC`.

## Timing

- Output stage is registered, first-word fall-through. A pixel written in cycle N is presented on `m_axis_*` in cycle N+1 at the earliest (latency 1).
- `m_axis_tvalid` stays 1 while the FIFO is non-empty.
- `tdata`/`tuser`/`tlast` are stable while `tvalid` is high and `tready` is low (AXI rule).
- `overflow` rises in the cycle after the offending `data_enable_in`.
- With `m_axis_tready` held 1, throughput is one pixel per cycle and the FIFO never exceeds 1 entry.

## Configuration

- Macro: `PIXEL_STREAM_AXIS_STATS_EN`.
- Defined:
  - `frame_count` increments on each written pixel with `frame_start_in`=1.
  - `drop_count` increments on each discarded pixel in `SYNC`, in `DROP`, or at overflow.
  - Both counters saturate at 16'hFFFF and are cleared only by reset.
- Not defined: both ports are tied to 0, and no counter logic is synthesised.
- Stream behaviour is identical in both builds.

## Test plan

- Reset, then a 4x2 frame (8 pixels, `frame_start` on pixel 0, `line_end` on pixels 3 and 7) with `tready`=1 -> 8 beats in order; `tuser` only on beat 0; `tlast` on beats 3 and 7; each beat 1 cycle after input; `overflow`=0.
- 3 pixels without `frame_start`, then a frame start -> the first 3 are dropped (`drop_count`=3 with STATS_EN); output starts with `tuser`=1.
- `tready`=0, 17 consecutive pixels at `FIFO_DEPTH`=16 -> `overflow`=1 on the 18th cycle; the following pixels are dropped; after `tready`=1, exactly 16 beats drain; output resumes at the next `frame_start` with `tuser`=1.
- FIFO full with `tready`=1 and `data_enable_in`=1 in the same cycle -> no overflow; `count` stays 16; data order preserved.
- `tready` toggled randomly at 50% across 2 frames -> `tdata`/`tuser`/`tlast` held while stalled; no loss while occupancy < 16; `frame_count`=2.
- `resetn` pulsed low mid-line -> outputs go to reset values immediately (asynchronous); after release, pixels are ignored until the next `frame_start`.
